// File: rtl/matrix_ram_pkg.sv
// Shared types for the matrix_ram arbiter.
// The optional read-after-write forwarding path is enabled by MATRIX_RAM_ARB_FWD_EN.
package matrix_ram_pkg;

  localparam int RD_LAT   = 2;   // RAM registered read latency in cycles
  localparam int CLIENT_W = 1;   // client id width (two clients per side)
  localparam int FWD_DW   = 64;  // storage width of the forwarded write word

  typedef struct packed {
    logic                vld;
    logic [CLIENT_W-1:0] id;
    logic                oor;
`ifdef MATRIX_RAM_ARB_FWD_EN
    logic                fwd;
    logic [FWD_DW-1:0]   fwd_data;
`endif
  } rd_tag_t;

endpackage

// File: rtl/matrix_ram_arb_rr_arb2.sv
// Two-request round-robin arbiter.
// ptr names the client that wins a tie; it moves to the other client after every grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic ptr;

  // Grant a lone requester, or the favoured one on a tie; nothing during reset.
  always_comb begin
    gnt = 2'b00;
    if (!rst) begin
      if (req == 2'b11) gnt[ptr] = 1'b1;
      else              gnt      = req;
    end
  end

  // After granting client c, favour the other client next time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       ptr <= 1'b0;
    else if (|gnt) ptr <= gnt[0];
  end

endmodule

// File: rtl/matrix_ram_arb.sv
// Two-writer / two-reader arbiter in front of one matrix_ram (2-cycle read path).
// Reads are tagged through the RAM latency and steered back to the requester.
// Optional same-cycle read-after-write forwarding: define MATRIX_RAM_ARB_FWD_EN.
module matrix_ram_arb
  import matrix_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_NUM   = 32,
  parameter int ADNW       = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr0_req,
  input  logic [ADNW-1:0]       wr0_addr,
  input  logic [DATA_WIDTH-1:0] wr0_data,
  output logic                  wr0_gnt,
  input  logic                  wr1_req,
  input  logic [ADNW-1:0]       wr1_addr,
  input  logic [DATA_WIDTH-1:0] wr1_data,
  output logic                  wr1_gnt,
  input  logic                  rd0_req,
  input  logic [ADNW-1:0]       rd0_addr,
  output logic                  rd0_gnt,
  output logic                  rd0_vld,
  output logic [DATA_WIDTH-1:0] rd0_data,
  input  logic                  rd1_req,
  input  logic [ADNW-1:0]       rd1_addr,
  output logic                  rd1_gnt,
  output logic                  rd1_vld,
  output logic [DATA_WIDTH-1:0] rd1_data,
  output logic                  ram_we,
  output logic [ADNW-1:0]       ram_addra,
  output logic [DATA_WIDTH-1:0] ram_dina,
  output logic [ADNW-1:0]       ram_addrb,
  input  logic [DATA_WIDTH-1:0] ram_doutb,
  output logic                  err_oor
);

  localparam logic [ADNW:0] ADDR_LIM = (ADNW+1)'(ADDR_NUM);

  logic [1:0] wgnt, rgnt;
  logic       wr_oor, rd_oor;

  rd_tag_t tag_in;
  rd_tag_t tag_q [RD_LAT];
  rd_tag_t tag_out;

  logic [1:0]                 rd_vld_q;
  logic [1:0][DATA_WIDTH-1:0] rd_data_q;
  logic [DATA_WIDTH-1:0]      ret_data;

  rr_arb2 u_wr_arb (.clk(clk), .rst(rst), .req({wr1_req, wr0_req}), .gnt(wgnt));
  rr_arb2 u_rd_arb (.clk(clk), .rst(rst), .req({rd1_req, rd0_req}), .gnt(rgnt));

  assign wr0_gnt = wgnt[0];
  assign wr1_gnt = wgnt[1];
  assign rd0_gnt = rgnt[0];
  assign rd1_gnt = rgnt[1];

  // Write mux: client 1 only when granted, otherwise client 0 passes through.
  always_comb begin
    ram_addra = wgnt[1] ? wr1_addr : wr0_addr;
    ram_dina  = wgnt[1] ? wr1_data : wr0_data;
    wr_oor    = {1'b0, ram_addra} >= ADDR_LIM;
    ram_we    = (|wgnt) && !wr_oor;
  end

  // Read address mux and the tag entering the latency pipeline.
  always_comb begin
    ram_addrb  = rgnt[1] ? rd1_addr : rd0_addr;
    rd_oor     = {1'b0, ram_addrb} >= ADDR_LIM;
    tag_in     = '0;
    tag_in.vld = |rgnt;
    tag_in.id  = CLIENT_W'(rgnt[1]);
    tag_in.oor = (|rgnt) && rd_oor;
`ifdef MATRIX_RAM_ARB_FWD_EN
    // ram_we already excludes out-of-range writes, so a match is in range.
    tag_in.fwd      = (|rgnt) && ram_we && (ram_addra == ram_addrb);
    tag_in.fwd_data = FWD_DW'(ram_dina);
`endif
  end

  // Tag shift register aligned with the RAM read latency; reset drops in-flight reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= tag_in;
      for (int i = 1; i < RD_LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign tag_out = tag_q[RD_LAT-1];

  // Returned word: zero for out-of-range, forwarded write data on a same-cycle hit.
  always_comb begin
    ret_data = ram_doutb;
`ifdef MATRIX_RAM_ARB_FWD_EN
    if (tag_out.fwd) ret_data = DATA_WIDTH'(tag_out.fwd_data);
`endif
    if (tag_out.oor) ret_data = '0;
  end

  // Output register: only the tagged client's data and vld change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_vld_q  <= '0;
      rd_data_q <= '0;
    end else begin
      rd_vld_q <= '0;
      if (tag_out.vld) begin
        rd_vld_q[tag_out.id]  <= 1'b1;
        rd_data_q[tag_out.id] <= ret_data;
      end
    end
  end

  assign rd0_vld  = rd_vld_q[0];
  assign rd1_vld  = rd_vld_q[1];
  assign rd0_data = rd_data_q[0];
  assign rd1_data = rd_data_q[1];

  // Sticky flag for any granted out-of-range access.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                              err_oor <= 1'b0;
    else if (((|wgnt) && wr_oor) || ((|rgnt) && rd_oor)) err_oor <= 1'b1;
  end

endmodule

// File: tb/tb_matrix_ram_arb.sv
// Directed bench for matrix_ram_arb with a behavioural 2-cycle-read RAM model.
module tb_matrix_ram_arb;

  localparam int DW = 64;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr0_req = 0, wr1_req = 0, rd0_req = 0, rd1_req = 0;
  logic [AW-1:0] wr0_addr = 0, wr1_addr = 0, rd0_addr = 0, rd1_addr = 0;
  logic [DW-1:0] wr0_data = 0, wr1_data = 0;
  logic          wr0_gnt, wr1_gnt, rd0_gnt, rd1_gnt, rd0_vld, rd1_vld;
  logic [DW-1:0] rd0_data, rd1_data;
  logic          ram_we, err_oor;
  logic [AW-1:0] ram_addra, ram_addrb;
  logic [DW-1:0] ram_dina, ram_doutb;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  matrix_ram_arb #(.DATA_WIDTH(DW), .ADDR_NUM(32), .ADNW(AW)) dut (
    .clk(clk), .rst(rst),
    .wr0_req(wr0_req), .wr0_addr(wr0_addr), .wr0_data(wr0_data), .wr0_gnt(wr0_gnt),
    .wr1_req(wr1_req), .wr1_addr(wr1_addr), .wr1_data(wr1_data), .wr1_gnt(wr1_gnt),
    .rd0_req(rd0_req), .rd0_addr(rd0_addr), .rd0_gnt(rd0_gnt), .rd0_vld(rd0_vld), .rd0_data(rd0_data),
    .rd1_req(rd1_req), .rd1_addr(rd1_addr), .rd1_gnt(rd1_gnt), .rd1_vld(rd1_vld), .rd1_data(rd1_data),
    .ram_we(ram_we), .ram_addra(ram_addra), .ram_dina(ram_dina),
    .ram_addrb(ram_addrb), .ram_doutb(ram_doutb), .err_oor(err_oor)
  );

  // RAM model: synchronous write, two registered read stages (read-before-write).
  logic [DW-1:0] mem [64];
  logic [DW-1:0] rd_s1;
  always @(posedge clk) begin
    if (ram_we) mem[ram_addra] <= ram_dina;
    rd_s1     <= mem[ram_addrb];
    ram_doutb <= rd_s1;
  end

  task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; step(); step(); rst = 1'b0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr0_req = 1; wr0_addr = a; wr0_data = d; #1;
    chk("wr_gnt", wr0_gnt, 1);
    step(); wr0_req = 0;
  endtask

  // Issue one read and check the t+3 return.
  task automatic rd_chk(input string tag, input int id, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    if (id == 0) begin rd0_req = 1; rd0_addr = a; end
    else         begin rd1_req = 1; rd1_addr = a; end
    #1;
    chk({tag, "_gnt"}, (id == 0) ? rd0_gnt : rd1_gnt, 1);
    step(); rd0_req = 0; rd1_req = 0;
    step(); step();
    chk({tag, "_vld"},  (id == 0) ? rd0_vld  : rd1_vld, 1);
    chk({tag, "_data"}, (id == 0) ? rd0_data : rd1_data, exp);
  endtask

  initial begin
    int k0, k1;
    logic [DW-1:0] exp_raw;

    // Reset state
    #1;
    chk("rst_wr0_gnt", wr0_gnt, 0);
    chk("rst_rd0_vld", rd0_vld, 0);
    chk("rst_rd0_data", rd0_data, 0);
    chk("rst_err", err_oor, 0);
    chk("rst_we", ram_we, 0);
    step(); step(); rst = 1'b0;

    // Single read
    wr(5, 64'hA5A5);
    rd0_req = 1; rd0_addr = 5; #1;
    chk("sr_gnt", rd0_gnt, 1);
    chk("sr_addrb", ram_addrb, 5);
    chk("sr_rd1_gnt", rd1_gnt, 0);
    step(); rd0_req = 0;
    chk("sr_vld_t1", rd0_vld, 0);
    step();
    chk("sr_vld_t2", rd0_vld, 0);
    step();
    chk("sr_vld_t3", rd0_vld, 1);
    chk("sr_data", rd0_data, 64'hA5A5);
    chk("sr_rd1_vld", rd1_vld, 0);
    step();
    chk("sr_vld_t4", rd0_vld, 0);

    // Write contention
    do_reset();
    k0 = 0; k1 = 0;
    for (int i = 0; i < 6; i++) begin
      wr0_req = 1; wr0_addr = 1; wr0_data = 64'h100 + 64'(k0);
      wr1_req = 1; wr1_addr = 2; wr1_data = 64'h200 + 64'(k1);
      #1;
      chk($sformatf("ct_gnt0_%0d", i), wr0_gnt, (i % 2 == 0) ? 1 : 0);
      chk($sformatf("ct_gnt1_%0d", i), wr1_gnt, (i % 2 == 1) ? 1 : 0);
      chk($sformatf("ct_we_%0d", i), ram_we, 1);
      chk($sformatf("ct_addra_%0d", i), ram_addra, (i % 2 == 0) ? 1 : 2);
      chk($sformatf("ct_dina_%0d", i), ram_dina,
          (i % 2 == 0) ? 64'h100 + 64'(k0) : 64'h200 + 64'(k1));
      if (i % 2 == 0) k0++; else k1++;
      step();
    end
    wr0_req = 0; wr1_req = 0; #1;
    chk("ct_idle_we", ram_we, 0);
    chk("ct_mem1", mem[1], 64'h102);
    chk("ct_mem2", mem[2], 64'h202);

    // Alternating reads
    wr(3, 64'h33);
    wr(4, 64'h44);
    do_reset();
    for (int c = 0; c < 8; c++) begin
      rd0_req = (c < 4); rd0_addr = 3;
      rd1_req = (c < 4); rd1_addr = 4;
      #1;
      if (c < 4) begin
        chk($sformatf("ar_gnt0_%0d", c), rd0_gnt, (c % 2 == 0) ? 1 : 0);
        chk($sformatf("ar_gnt1_%0d", c), rd1_gnt, (c % 2 == 1) ? 1 : 0);
      end
      chk($sformatf("ar_vld0_%0d", c), rd0_vld, (c == 3 || c == 5) ? 1 : 0);
      chk($sformatf("ar_vld1_%0d", c), rd1_vld, (c == 4 || c == 6) ? 1 : 0);
      if (c == 3 || c == 5) chk($sformatf("ar_d0_%0d", c), rd0_data, 64'h33);
      if (c == 4 || c == 6) chk($sformatf("ar_d1_%0d", c), rd1_data, 64'h44);
      if (c == 5)           chk("ar_d1_hold", rd1_data, 64'h44);
      step();
    end
    rd0_req = 0; rd1_req = 0;

    // Same-cycle read-after-write
    wr(7, 64'h11);
    do_reset();
`ifdef MATRIX_RAM_ARB_FWD_EN
    exp_raw = 64'h22;
`else
    exp_raw = 64'h11;
`endif
    wr0_req = 1; wr0_addr = 7; wr0_data = 64'h22;
    rd0_req = 1; rd0_addr = 7; #1;
    chk("raw_wgnt", wr0_gnt, 1);
    chk("raw_rgnt", rd0_gnt, 1);
    step(); wr0_req = 0; rd0_req = 0;
    step(); step();
    chk("raw_vld", rd0_vld, 1);
    chk("raw_data", rd0_data, exp_raw);
    rd_chk("raw_later", 0, 7, 64'h22);

    // Out of range
    do_reset();
    wr0_req = 1; wr0_addr = 40; wr0_data = 64'hDEAD; #1;
    chk("oor_wgnt", wr0_gnt, 1);
    chk("oor_we", ram_we, 0);
    step(); wr0_req = 0;
    chk("oor_err", err_oor, 1);
    rd_chk("oor_prime", 1, 4, 64'h44);
    rd_chk("oor_rd", 1, 33, 64'h0);
    chk("oor_err_sticky", err_oor, 1);
    do_reset();
    chk("oor_err_clr", err_oor, 0);

    // Reset mid-flight
    rd0_req = 1; rd0_addr = 5; #1;
    chk("rmf_gnt", rd0_gnt, 1);
    step();
    rst = 1'b1;
    wr0_req = 1; wr0_addr = 5; wr0_data = 64'hBAD; #1;
    chk("rmf_rgnt", rd0_gnt, 0);
    chk("rmf_wgnt", wr0_gnt, 0);
    chk("rmf_we", ram_we, 0);
    chk("rmf_vld", rd0_vld, 0);
    chk("rmf_data", rd0_data, 0);
    chk("rmf_err", err_oor, 0);
    step();
    chk("rmf_vld_b", rd0_vld, 0);
    rst = 1'b0; rd0_req = 0; wr0_req = 0;
    for (int c = 0; c < 5; c++) begin
      step();
      chk($sformatf("rmf_after0_%0d", c), rd0_vld, 0);
      chk($sformatf("rmf_after1_%0d", c), rd1_vld, 0);
    end
    chk("rmf_mem5", mem[5], 64'hA5A5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
